training_scheduler: RTL and testbench

- Sequences a perceptron training run for the neuron_trainer datapath.
- Holds a small on-chip table of training samples (x1, x2, target). Streams the samples to the trainer one per cycle, epoch after epoch.
- Watches the trainer's error each cycle and stops when a whole epoch is within tolerance or the epoch budget is used up.
- Sits between the host/config logic and the trainer; drives the trainer's valid and sample inputs.

---
 rtl/training_scheduler.sv | 145 ++++++++++++++
 tb/tb_training_scheduler.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/training_scheduler.sv
// training_scheduler: streams a sample table to the perceptron trainer epoch by epoch until convergence, budget or abort
module training_scheduler #(
    parameter int SIGN = 1,
    parameter int Q_M = 15,
    parameter int Q_N = 16,
    parameter int N_SAMPLES = 4,
    parameter int MAX_EPOCHS = 1000,
    parameter logic [SIGN+Q_M+Q_N-1:0] TOLERANCE = 32'h0000_1000,
    localparam int W = SIGN + Q_M + Q_N,
    localparam int AW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [W-1:0]  wr_x1_i,
    input  logic [W-1:0]  wr_x2_i,
    input  logic [W-1:0]  wr_y_i,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [W-1:0]  error_i,
    output logic          train_valid_o,
    output logic [W-1:0]  train_x1_o,
    output logic [W-1:0]  train_x2_o,
    output logic [W-1:0]  train_y_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          converged_o,
    output logic [15:0]   epoch_cnt_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [W-1:0] MAG = {1'b0, {(W-1){1'b1}}};

    state_t state_q, state_d;
    logic [AW-1:0] idx_q, idx_d, idx_nx;
    logic [15:0] epoch_q, epoch_d, epoch_inc;
    logic clean_q, clean_d, conv_q, conv_d;
    logic clean_now, last, hit_max, wr_ok, wr_hit0;
    logic [W-1:0] x1_q, x1_d, x2_q, x2_d, y_q, y_d;
    logic [W-1:0] tbl_x1_q [N_SAMPLES];
    logic [W-1:0] tbl_x2_q [N_SAMPLES];
    logic [W-1:0] tbl_y_q  [N_SAMPLES];

    assign wr_ok     = (state_q == IDLE) && wr_en_i && (int'(wr_addr_i) < N_SAMPLES);
    assign wr_hit0   = wr_ok && (wr_addr_i == '0);
    assign clean_now = clean_q && ((error_i & MAG) <= (TOLERANCE & MAG));
    assign last      = int'(idx_q) == N_SAMPLES - 1;
    assign idx_nx    = idx_q + 1'b1;
    assign epoch_inc = (&epoch_q) ? epoch_q : epoch_q + 16'd1;
    assign hit_max   = (32'(epoch_q) + 32'd1) == $unsigned(MAX_EPOCHS);

    assign train_valid_o = state_q == RUN;
    assign busy_o        = state_q == RUN;
    assign done_o        = state_q == DONE;
    assign converged_o   = conv_q;
    assign epoch_cnt_o   = epoch_q;
    assign train_x1_o    = x1_q;
    assign train_x2_o    = x2_q;
    assign train_y_o     = y_q;

    // Sample table: host writes land only while idle
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < N_SAMPLES; i++) begin
                tbl_x1_q[i] <= '0;
                tbl_x2_q[i] <= '0;
                tbl_y_q[i]  <= '0;
            end
        end else if (wr_ok) begin
            tbl_x1_q[wr_addr_i] <= wr_x1_i;
            tbl_x2_q[wr_addr_i] <= wr_x2_i;
            tbl_y_q[wr_addr_i]  <= wr_y_i;
        end
    end

    // Control and presented-sample registers
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            epoch_q <= '0;
            clean_q <= 1'b1;
            conv_q  <= 1'b0;
            x1_q    <= '0;
            x2_q    <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            epoch_q <= epoch_d;
            clean_q <= clean_d;
            conv_q  <= conv_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            y_q     <= y_d;
        end
    end

    // Next state: start loads sample 0 (forwarding a same-cycle write), RUN advances or ends the epoch
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        epoch_d = epoch_q;
        clean_d = clean_q;
        conv_d  = conv_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        y_d     = y_q;
        if (state_q == IDLE) begin
            if (start_i) begin
                state_d = RUN;
                idx_d   = '0;
                epoch_d = '0;
                conv_d  = 1'b0;
                clean_d = 1'b1;
                x1_d    = wr_hit0 ? wr_x1_i : tbl_x1_q[0];
                x2_d    = wr_hit0 ? wr_x2_i : tbl_x2_q[0];
                y_d     = wr_hit0 ? wr_y_i  : tbl_y_q[0];
            end
        end else if (state_q == RUN) begin
            if (abort_i) begin
                state_d = DONE;
                conv_d  = 1'b0;
            end else if (last) begin
                epoch_d = epoch_inc;
                state_d = (clean_now || hit_max) ? DONE : RUN;
                conv_d  = clean_now;
                idx_d   = '0;
                clean_d = 1'b1;
                x1_d    = tbl_x1_q[0];
                x2_d    = tbl_x2_q[0];
                y_d     = tbl_y_q[0];
            end else begin
                idx_d   = idx_nx;
                clean_d = clean_now;
                x1_d    = tbl_x1_q[idx_nx];
                x2_d    = tbl_x2_q[idx_nx];
                y_d     = tbl_y_q[idx_nx];
            end
        end else begin
            state_d = IDLE;
        end
    end
endmodule

// File: tb/tb_training_scheduler.sv
// tb_training_scheduler: randomized directed runs checked against a cycle-count model of the training run
module tb_training_scheduler;
    localparam int N = 4;
    localparam int MAXE = 3;
    localparam logic [31:0] TOL = 32'h0000_1000;

    logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, start = 1'b0, abort = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [31:0] wx1 = '0, wx2 = '0, wy = '0, err = '0;
    logic valid, busy, done, conv;
    logic [31:0] tx1, tx2, ty;
    logic [15:0] epoch;

    int checks = 0;
    int passed = 0;
    logic [31:0] m_x1 [N];
    logic [31:0] m_x2 [N];
    logic [31:0] m_y  [N];

    training_scheduler #(.N_SAMPLES(N), .MAX_EPOCHS(MAXE), .TOLERANCE(TOL)) dut (
        .clk_i(clk), .reset_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_x1_i(wx1), .wr_x2_i(wx2), .wr_y_i(wy), .start_i(start), .abort_i(abort),
        .error_i(err), .train_valid_o(valid), .train_x1_o(tx1), .train_x2_o(tx2),
        .train_y_o(ty), .busy_o(busy), .done_o(done), .converged_o(conv), .epoch_cnt_o(epoch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic wr(input int a, input logic [31:0] x1, input logic [31:0] x2, input logic [31:0] y);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 2'(a); wx1 = x1; wx2 = x2; wy = y;
        m_x1[a] = x1; m_x2[a] = x2; m_y[a] = y;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // mode 0: all zero, 1: all 1.0, 2: all exactly TOL, 3: one TOL+1 in epoch 1, 4: random
    function automatic logic [31:0] gen_err(input int mode, input int k, input int bad_k);
        logic [31:0] mag;
        case (mode)
            0: return 32'h0;
            1: return 32'h0001_0000;
            2: return {1'($urandom_range(1)), TOL[30:0]};
            3: return (k == bad_k) ? {1'b1, 31'(TOL + 1)} : 32'h0;
            default: begin
                mag = ($urandom_range(3) != 0) ? 32'($urandom_range(TOL)) : TOL + 1 + 32'($urandom_range(32'hFFFF));
                return {1'($urandom_range(1)), mag[30:0]};
            end
        endcase
    endfunction

    task automatic run(input int mode, input int abort_at, input int wr_at, input bit wr0);
        int k, ep, bad_k;
        bit fin, clean, cv;
        logic [31:0] e;
        @(negedge clk);
        chk("idle_valid", 32'(valid), 0);
        start = 1'b1;
        if (wr0) begin
            wr_en = 1'b1; wr_addr = 2'd0;
            wx1 = $urandom; wx2 = $urandom; wy = $urandom;
            m_x1[0] = wx1; m_x2[0] = wx2; m_y[0] = wy;
        end
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        k = 0; ep = 0; clean = 1'b1; cv = 1'b0; fin = 1'b0;
        bad_k = $urandom_range(N - 1);
        while (!fin && k < N * MAXE + 1) begin
            chk($sformatf("run_valid k%0d", k), 32'(valid), 1);
            chk($sformatf("run_busy k%0d", k), 32'(busy), 1);
            chk($sformatf("run_done k%0d", k), 32'(done), 0);
            chk($sformatf("x1 k%0d", k), tx1, m_x1[k % N]);
            chk($sformatf("x2 k%0d", k), tx2, m_x2[k % N]);
            chk($sformatf("y k%0d", k), ty, m_y[k % N]);
            e = gen_err(mode, k, bad_k);
            err = e;
            abort = (k == abort_at);
            if (k == wr_at) begin
                wr_en = 1'b1; wr_addr = 2'(k % N); wx1 = $urandom; wx2 = $urandom; wy = $urandom;
            end
            if (abort) begin
                fin = 1'b1; cv = 1'b0;
            end else begin
                if (e[30:0] > TOL[30:0]) clean = 1'b0;
                if (k % N == N - 1) begin
                    ep++;
                    if (clean) begin fin = 1'b1; cv = 1'b1; end
                    else if (ep == MAXE) begin fin = 1'b1; cv = 1'b0; end
                    else clean = 1'b1;
                end
            end
            k++;
            @(negedge clk);
            abort = 1'b0; wr_en = 1'b0; err = '0;
        end
        chk("done_pulse", 32'(done), 1);
        chk("done_valid", 32'(valid), 0);
        chk("done_busy", 32'(busy), 0);
        chk("done_conv", 32'(conv), 32'(cv));
        chk("done_epoch", 32'(epoch), 32'(ep));
        @(negedge clk);
        chk("after_done", 32'(done), 0);
        chk("after_valid", 32'(valid), 0);
        chk("hold_conv", 32'(conv), 32'(cv));
        chk("hold_epoch", 32'(epoch), 32'(ep));
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin m_x1[i] = '0; m_x2[i] = '0; m_y[i] = '0; end
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_conv", 32'(conv), 0);
        chk("rst_epoch", 32'(epoch), 0);
        chk("rst_x1", tx1, 0);
        rst_n = 1'b1;
        wr(0, 32'h0, 32'h0, 32'h0);
        wr(1, 32'h0, 32'h0001_0000, 32'h0);
        wr(2, 32'h0001_0000, 32'h0, 32'h0);
        wr(3, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
        run(0, -1, -1, 1'b0);
        run(1, -1, -1, 1'b0);
        run(2, -1, -1, 1'b0);
        run(3, -1, -1, 1'b0);
        run(0, 2, 1, 1'b0);
        run(0, -1, -1, 1'b0);
        run(0, -1, -1, 1'b1);
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < N; a++) wr(a, $urandom, $urandom, $urandom);
            run(4, ($urandom_range(1) != 0) ? int'($urandom_range(N * MAXE - 1)) : -1, int'($urandom_range(5)), 1'($urandom_range(1)));
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", 32'(valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(valid), 0);
        chk("async_busy", 32'(busy), 0);
        chk("async_done", 32'(done), 0);
        chk("async_conv", 32'(conv), 0);
        chk("async_epoch", 32'(epoch), 0);
        chk("async_x1", tx1, 0);
        chk("async_y", ty, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin m_x1[i] = '0; m_x2[i] = '0; m_y[i] = '0; end
        run(0, -1, -1, 1'b0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
